// File: rtl/openhw_ahbcacheif.sv
// AHB-Lite burst engine between a cache line port and the EBU LSU port.
// Moves one full line per request as an INCR burst (fetch or writeback).
module openhw_ahbcacheif #(
  parameter int PA_BITS = 56,
  parameter int AHBW    = 64,
  parameter int BEATS   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                CacheBusRW,
  input  logic [PA_BITS-1:0]        CacheBusAdr,
  input  logic [AHBW-1:0]           CacheBusWriteData,
  output logic [$clog2(BEATS)-1:0]  BeatCount,
  output logic [BEATS*AHBW-1:0]     FetchBuffer,
  output logic                      CacheBusAck,
  output logic                      CacheBusStall,
  output logic                      CacheBusErr,
  output logic [PA_BITS-1:0]        HADDR,
  output logic [1:0]                HTRANS,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic [AHBW-1:0]           HWDATA,
  output logic [AHBW/8-1:0]         HWSTRB,
  input  logic                      HREADY,
  input  logic                      HRESP,
  input  logic [AHBW-1:0]           HRDATA,
  output logic [1:0]                dbg_state
);

  localparam int BW    = $clog2(BEATS);
  localparam int BYTEB = $clog2(AHBW/8);
  localparam int OFFB  = BW + BYTEB;
  localparam logic [2:0] BURST_CODE = (BEATS == 16) ? 3'b111 :
                                      (BEATS == 8)  ? 3'b101 : 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Cache handshake: the cache holds CacheBusRW (and the address) steady
  // until it sees the one-cycle CacheBusAck; CacheBusStall is high from the
  // request cycle until the ack cycle, where it drops.

  state_t                state, state_nxt;
  logic [BW:0]           adr_count;
  logic [BW-1:0]         data_count;
  logic [PA_BITS-1:0]    base;
  logic                  wr_q;
  logic                  err_q;
  logic [BEATS*AHBW-1:0] fetch_buf;

  logic                  req;
  logic                  req_wr;
  logic                  accept;
  logic                  beat_done;
  logic                  last_beat;
  logic [PA_BITS-1:0]    req_base;
  logic [PA_BITS-1:0]    burst_adr;
  logic                  unused_adr_bits;

  assign req       = |CacheBusRW;
  assign req_wr    = (CacheBusRW == 2'b01);
  assign accept    = (state == S_IDLE) && req && HREADY;
  assign beat_done = (state == S_BURST) && HREADY;
  assign last_beat = (data_count == BW'(BEATS-1));
  assign req_base  = {CacheBusAdr[PA_BITS-1:OFFB], {OFFB{1'b0}}};
  assign unused_adr_bits = ^CacheBusAdr[OFFB-1:0];

  // Beat index only replaces line-offset bits, so no carry into the tag.
  assign burst_adr = {base[PA_BITS-1:OFFB], adr_count[BW-1:0], {BYTEB{1'b0}}};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req && HREADY)        state_nxt = S_BURST;
      S_BURST: if (HREADY && last_beat)  state_nxt = S_DONE;
      S_DONE:                            state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    HTRANS        = 2'b00;
    HADDR         = req_base;
    HWRITE        = 1'b0;
    CacheBusAck   = 1'b0;
    CacheBusStall = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          HTRANS        = 2'b10;
          HWRITE        = req_wr;
          CacheBusStall = 1'b1;
        end
      end
      S_BURST: begin
        HADDR         = burst_adr;
        HTRANS        = (adr_count < (BW+1)'(BEATS)) ? 2'b11 : 2'b00;
        HWRITE        = wr_q;
        CacheBusStall = 1'b1;
      end
      S_DONE: begin
        HADDR       = burst_adr;
        HWRITE      = wr_q;
        CacheBusAck = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters, sampled request and line buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      adr_count  <= '0;
      data_count <= '0;
      base       <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      fetch_buf  <= '0;
    end else if (accept) begin
      base       <= req_base;
      wr_q       <= req_wr;
      adr_count  <= (BW+1)'(1);
      data_count <= '0;
      err_q      <= 1'b0;
    end else if (beat_done) begin
      if (adr_count < (BW+1)'(BEATS)) adr_count <= adr_count + 1'b1;
      data_count <= data_count + 1'b1;
      if (HRESP) err_q <= 1'b1;
      if (!wr_q) fetch_buf[int'(data_count)*AHBW +: AHBW] <= HRDATA;
    end
  end

  assign BeatCount   = data_count;
  assign FetchBuffer = fetch_buf;
  assign CacheBusErr = err_q;
  assign HSIZE       = 3'(BYTEB);
  assign HBURST      = BURST_CODE;
  assign HWDATA      = CacheBusWriteData;
  assign HWSTRB      = '1;
  assign dbg_state   = state;

endmodule
